// File: rtl/apb3_master_mux.sv
// APB3 master bridge: one user request at a time, routed to one of NUM_SLAVES slaves by address
// region, with wait states, PSLVERR capture, decode errors and a PREADY timeout watchdog.
module apb3_master_mux #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SLAVE_SPAN = 1024,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             data_valid,
  input  logic                             data_dir,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            data,
  output logic                             req_ready,
  output logic                             transaction_done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             resp_err,
  output logic                             resp_timeout,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic                             PENABLE,
  output logic [NUM_SLAVES-1:0]            PSEL,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDecerr} state_e;

  state_e          state_q;
  logic [IdxW-1:0] sel_q;
  logic [CntW-1:0] wait_cnt_q;

  logic [31:0]           req_idx;
  logic                  req_hit;
  logic [IdxW-1:0]       req_sel;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // Region decode of the incoming request address.
  always_comb begin
    req_idx = 32'(addr) / SLAVE_SPAN;
    req_hit = (req_idx < NUM_SLAVES);
    req_sel = req_idx[IdxW-1:0];
  end

  // Only the selected slave's response lane is ever observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IdxW'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The dead cycle after done stops a still-held data_valid from being taken twice.
  always_comb begin
    req_ready = (state_q == StIdle) && !transaction_done;
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q          <= StIdle;
      sel_q            <= '0;
      wait_cnt_q       <= '0;
      PSEL             <= '0;
      PENABLE          <= 1'b0;
      PWRITE           <= 1'b0;
      PADDR            <= '0;
      PWDATA           <= '0;
      rdata            <= '0;
      resp_err         <= 1'b0;
      resp_timeout     <= 1'b0;
      transaction_done <= 1'b0;
    end else begin
      transaction_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (data_valid && req_ready) begin
            PADDR      <= addr;
            PWRITE     <= data_dir;
            PWDATA     <= data;
            sel_q      <= req_sel;
            wait_cnt_q <= '0;
            if (req_hit) begin
              PSEL    <= NUM_SLAVES'(1) << req_sel;
              state_q <= StSetup;
            end else begin
              state_q <= StDecerr;
            end
          end
        end
        StSetup: begin
          PENABLE <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          if (sel_ready) begin
            // A ready arriving on the last permitted cycle still wins over the watchdog.
            resp_err     <= sel_err;
            resp_timeout <= 1'b0;
            if (!PWRITE) begin
              rdata <= sel_err ? '0 : sel_rdata;
            end
            PSEL             <= '0;
            PENABLE          <= 1'b0;
            transaction_done <= 1'b1;
            state_q          <= StIdle;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == CntMax)) begin
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            if (!PWRITE) begin
              rdata <= '0;
            end
            PSEL             <= '0;
            PENABLE          <= 1'b0;
            transaction_done <= 1'b1;
            state_q          <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StDecerr: begin
          resp_err     <= 1'b1;
          resp_timeout <= 1'b0;
          if (!PWRITE) begin
            rdata <= '0;
          end
          transaction_done <= 1'b1;
          state_q          <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_master_mux.sv
// Bench for apb3_master_mux: slave models, a transaction-level timing/result model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_apb3_master_mux;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int NS   = 2;
  localparam int SPAN = 1024;
  localparam int TO   = 16;

  logic             PCLK = 1'b0;
  logic             PRESETn = 1'b1;
  logic             data_valid = 1'b0;
  logic             data_dir = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [DW-1:0]    data = '0;
  logic             req_ready;
  logic             transaction_done;
  logic [DW-1:0]    rdata;
  logic             resp_err;
  logic             resp_timeout;
  logic [AW-1:0]    PADDR;
  logic             PWRITE;
  logic [DW-1:0]    PWDATA;
  logic             PENABLE;
  logic [NS-1:0]    PSEL;
  logic [NS*DW-1:0] PRDATA = '0;
  logic [NS-1:0]    PREADY = '0;
  logic [NS-1:0]    PSLVERR = '0;

  apb3_master_mux #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_SLAVES(NS),
    .SLAVE_SPAN(SPAN),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK            (PCLK),
    .PRESETn         (PRESETn),
    .data_valid      (data_valid),
    .data_dir        (data_dir),
    .addr            (addr),
    .data            (data),
    .req_ready       (req_ready),
    .transaction_done(transaction_done),
    .rdata           (rdata),
    .resp_err        (resp_err),
    .resp_timeout    (resp_timeout),
    .PADDR           (PADDR),
    .PWRITE          (PWRITE),
    .PWDATA          (PWDATA),
    .PENABLE         (PENABLE),
    .PSEL            (PSEL),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Slave models: wait_cfg[i] PREADY-low ACCESS cycles, then ready with PSLVERR = err_cfg[i].
  logic [DW-1:0] smem [NS][SPAN];
  int            wait_cfg [NS];
  bit            err_cfg [NS];
  int            acc_cnt [NS];

  always @(posedge PCLK) begin
    #2;
    for (int i = 0; i < NS; i++) begin
      if (PSEL[i] && PENABLE) begin
        acc_cnt[i]++;
        if (acc_cnt[i] > wait_cfg[i]) begin
          PREADY[i]  = 1'b1;
          PSLVERR[i] = err_cfg[i];
          if (PWRITE) begin
            if (!err_cfg[i]) smem[i][int'(PADDR) % SPAN] = PWDATA;
            PRDATA[i*DW +: DW] = DW'($urandom);
          end else begin
            PRDATA[i*DW +: DW] = smem[i][int'(PADDR) % SPAN];
          end
        end else begin
          PREADY[i]          = 1'b0;
          PSLVERR[i]         = 1'($urandom_range(0, 1));
          PRDATA[i*DW +: DW] = DW'($urandom);
        end
      end else begin
        // Unselected / non-ACCESS lanes carry noise the DUT must ignore.
        acc_cnt[i]         = 0;
        PREADY[i]          = 1'($urandom_range(0, 1));
        PSLVERR[i]         = 1'($urandom_range(0, 1));
        PRDATA[i*DW +: DW] = DW'($urandom);
      end
    end
  end

  // Reference model: one queue entry per future cycle, built when a request is accepted.
  typedef struct {
    logic [NS-1:0] psel;
    bit            pen;
    bit            done;
    logic [DW-1:0] rd;
    bit            err;
    bit            to;
  } ent_t;

  function automatic ent_t mk(logic [NS-1:0] p, bit pe, bit dn, logic [DW-1:0] rd, bit er, bit t);
    ent_t x;
    x.psel = p; x.pen = pe; x.done = dn; x.rd = rd; x.err = er; x.to = t;
    return x;
  endfunction

  ent_t          sched[$];
  logic [DW-1:0] ref_mem [NS*SPAN];
  logic [AW-1:0] e_paddr = '0;
  bit            e_pwrite = 1'b0;
  logic [DW-1:0] e_pwdata = '0;
  logic [DW-1:0] e_rdata = '0;
  bit            e_err = 1'b0;
  bit            e_to = 1'b0;
  bit            chk_en = 1'b0;

  always @(negedge PCLK) begin : model
    ent_t          cur;
    bit            idle;
    int            idx, w, len;
    bit            er, tmo;
    logic [NS-1:0] oh;
    logic [DW-1:0] rdv;
    idle = (sched.size() == 0);
    if (!idle) begin
      cur = sched.pop_front();
      if (cur.done) begin
        e_rdata = cur.rd;
        e_err   = cur.err;
        e_to    = cur.to;
      end
    end else begin
      cur = mk('0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    if (chk_en) begin
      check("psel", 32'(PSEL), 32'(cur.psel));
      check("penable", 32'(PENABLE), 32'(cur.pen));
      check("done", 32'(transaction_done), 32'(cur.done));
      check("req_ready", 32'(req_ready), 32'(idle));
      check("paddr", 32'(PADDR), 32'(e_paddr));
      check("pwrite", 32'(PWRITE), 32'(e_pwrite));
      check("pwdata", 32'(PWDATA), 32'(e_pwdata));
      check("rdata", 32'(rdata), 32'(e_rdata));
      check("resp_err", 32'(resp_err), 32'(e_err));
      check("resp_timeout", 32'(resp_timeout), 32'(e_to));
    end
    // PRESETn is driven just after an edge, so its level here is what the next edge samples.
    if (PRESETn) begin
      sched.delete();
      e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0;
      e_rdata = '0; e_err = 1'b0; e_to = 1'b0;
    end else if (idle && data_valid) begin
      idx      = int'(addr) / SPAN;
      e_paddr  = addr;
      e_pwrite = data_dir;
      e_pwdata = data;
      if (idx >= NS) begin
        sched.push_back(mk('0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
        sched.push_back(mk('0, 1'b0, 1'b1, data_dir ? e_rdata : '0, 1'b1, 1'b0));
      end else begin
        w   = wait_cfg[idx];
        er  = err_cfg[idx];
        tmo = (TO > 0) && (w > TO);
        len = tmo ? TO + 1 : w + 1;
        oh  = NS'(1) << idx;
        sched.push_back(mk(oh, 1'b0, 1'b0, '0, 1'b0, 1'b0));
        for (int k = 0; k < len; k++) sched.push_back(mk(oh, 1'b1, 1'b0, '0, 1'b0, 1'b0));
        if (tmo) begin
          rdv = data_dir ? e_rdata : '0;
          sched.push_back(mk('0, 1'b0, 1'b1, rdv, 1'b1, 1'b1));
        end else begin
          rdv = data_dir ? e_rdata : (er ? '0 : ref_mem[int'(addr)]);
          if (data_dir && !er) ref_mem[int'(addr)] = data;
          sched.push_back(mk('0, 1'b0, 1'b1, rdv, er, 1'b0));
        end
      end
    end
  end

  // Called just after an edge; returns cycles until done is seen, ACCESS cycles and PSELs seen.
  task automatic run_txn(input bit dir, input int a, input int d, output int lat, output int acc,
                         output logic [NS-1:0] seen);
    data_valid = 1'b1;
    data_dir   = dir;
    addr       = AW'(a);
    data       = DW'(d);
    lat  = 0;
    acc  = 0;
    seen = '0;
    for (int k = 0; k < 200; k++) begin
      @(posedge PCLK);
      #1;
      lat++;
      seen |= PSEL;
      if (PENABLE) acc++;
      if (transaction_done) break;
    end
    if (!transaction_done) begin
      n_total++;
      $display("FAIL txn_wait: no transaction_done within 200 cycles, got lat %0d, addr %0h", lat, a);
    end
  endtask

  task automatic idle_cycle();
    data_valid = 1'b0;
    @(posedge PCLK);
    #1;
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL sim_watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int            lat, acc, a, p;
    logic [NS-1:0] seen;
    logic [DW-1:0] v;
    for (int i = 0; i < NS * SPAN; i++) begin
      v = DW'($urandom);
      ref_mem[i] = v;
      smem[i / SPAN][i % SPAN] = v;
    end
    ref_mem[1030] = 8'h5A;
    smem[1][6]    = 8'h5A;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0;
      err_cfg[i]  = 1'b0;
    end
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    chk_en  = 1'b1;
    idle_cycle();

    // Zero-wait write to slave 0.
    run_txn(1'b1, 8, 3, lat, acc, seen);
    check("t1_lat", lat, 3);
    check("t1_psel_seen", 32'(seen), 32'h1);
    check("t1_access", acc, 1);
    check("t1_err", 32'(resp_err), 0);
    check("t1_slave_mem", 32'(smem[0][8]), 32'h3);
    idle_cycle();

    // Read slave 1 with two wait states.
    wait_cfg[1] = 2;
    run_txn(1'b0, 1030, 0, lat, acc, seen);
    check("t2_lat", lat, 5);
    check("t2_access", acc, 3);
    check("t2_psel_seen", 32'(seen), 32'h2);
    check("t2_rdata", 32'(rdata), 32'h5A);
    wait_cfg[1] = 0;
    idle_cycle();

    // Write with PSLVERR leaves rdata alone; a clean read then clears the error.
    err_cfg[0] = 1'b1;
    run_txn(1'b1, 20, 8'h77, lat, acc, seen);
    check("t4_err", 32'(resp_err), 1);
    check("t4_rdata_kept", 32'(rdata), 32'h5A);
    err_cfg[0] = 1'b0;
    idle_cycle();
    run_txn(1'b0, 8, 0, lat, acc, seen);
    check("t4_clear_err", 32'(resp_err), 0);
    check("t4_read_back", 32'(rdata), 32'h3);
    idle_cycle();

    // Decode error: no bus activity.
    run_txn(1'b0, 4002, 0, lat, acc, seen);
    check("t3_lat", lat, 2);
    check("t3_psel_seen", 32'(seen), 0);
    check("t3_err", 32'(resp_err), 1);
    check("t3_timeout", 32'(resp_timeout), 0);
    check("t3_rdata", 32'(rdata), 0);
    idle_cycle();

    // Stuck slave 1: watchdog abort, then a normal transfer.
    wait_cfg[1] = 255;
    run_txn(1'b0, 1500, 0, lat, acc, seen);
    check("t5_lat", lat, TO + 3);
    check("t5_access", acc, TO + 1);
    check("t5_err", 32'(resp_err), 1);
    check("t5_timeout", 32'(resp_timeout), 1);
    wait_cfg[1] = 0;
    idle_cycle();
    run_txn(1'b1, 1100, 8'h44, lat, acc, seen);
    check("t5_next_lat", lat, 3);
    check("t5_next_err", 32'(resp_err), 0);
    check("t5_next_timeout", 32'(resp_timeout), 0);
    idle_cycle();

    // Ready on the very cycle the counter reaches the limit counts as success.
    wait_cfg[0] = TO;
    run_txn(1'b0, 8, 0, lat, acc, seen);
    check("edge_lat", lat, TO + 3);
    check("edge_err", 32'(resp_err), 0);
    check("edge_rdata", 32'(rdata), 32'h3);
    wait_cfg[0] = 0;

    // data_valid held across done: the new request waits out the dead cycle.
    run_txn(1'b0, 1030, 0, lat, acc, seen);
    check("b2b_lat", lat, 4);
    check("b2b_rdata", 32'(rdata), 32'h5A);
    idle_cycle();

    // Reset during ACCESS aborts silently.
    wait_cfg[1] = 10;
    data_valid  = 1'b1;
    data_dir    = 1'b0;
    addr        = AW'(1030);
    repeat (4) @(posedge PCLK);
    #1;
    PRESETn    = 1'b1;
    data_valid = 1'b0;
    @(posedge PCLK);
    #1;
    check("rst_psel", 32'(PSEL), 0);
    check("rst_penable", 32'(PENABLE), 0);
    check("rst_done", 32'(transaction_done), 0);
    PRESETn     = 1'b0;
    wait_cfg[1] = 0;
    repeat (3) idle_cycle();

    // Randomized traffic; every cycle is checked by the model process.
    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NS * SPAN - 1)
                                     : $urandom_range(NS * SPAN, (1 << AW) - 1);
      for (int i = 0; i < NS; i++) begin
        p = $urandom_range(0, 9);
        if (p < 7) wait_cfg[i] = $urandom_range(0, 3);
        else if (p < 9) wait_cfg[i] = $urandom_range(TO - 1, TO + 1);
        else wait_cfg[i] = 0;
        err_cfg[i] = ($urandom_range(0, 3) == 0);
      end
      run_txn(1'($urandom_range(0, 1)), a, $urandom_range(0, 255), lat, acc, seen);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) idle_cycle();
      end
    end
    repeat (4) idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb3_master_mux.md
# apb3_master_mux

Parametrised APB3 master bridge, the next generation of the single-slave master in the APB3 top. Accepts the same user request handshake (data, addr, data_dir, data_valid, transaction_done) and issues APB3 transfers to one of NUM_SLAVES slaves, selected by address region. Adds wait-state support via PREADY, per-slave PSLVERR capture, address-decode errors without bus activity, and a PREADY timeout watchdog.

## Interface
- ADDR_WIDTH, 12: width of addr and PADDR.
- DATA_WIDTH, 8: width of data, rdata, PWDATA and each PRDATA lane.
- NUM_SLAVES, 2: number of PSEL lines, 1..8.
- SLAVE_SPAN, 1024: bytes per slave; slave i owns [i*SLAVE_SPAN, (i+1)*SLAVE_SPAN).
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort; 0 disables the watchdog.

- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-high (asserted = 1).
- data_valid  in  1  request present; level, held by requester until transaction_done.
- data_dir  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  full request address.
- data  in  DATA_WIDTH  write data.
- req_ready  out  1  high when a request will be accepted this cycle.
- transaction_done  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  read data of last completed read.
- resp_err  out  1  error status of last transaction (valid with done, held until next done).
- resp_timeout  out  1  last error was a watchdog abort.
- PADDR  out  ADDR_WIDTH  full address (not slave-local).
- PWRITE  out  1; PWDATA  out  DATA_WIDTH; PENABLE  out  1.
- PSEL  out  NUM_SLAVES  one-hot select.
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  lane i = slave i.
- PREADY  in  NUM_SLAVES; PSLVERR  in  NUM_SLAVES.

## Operation
- States: IDLE, SETUP, ACCESS, DECERR.
- req_ready = (state == IDLE) && !transaction_done (one dead cycle after each completion, so a still-high data_valid is not re-accepted).
- IDLE: on data_valid && req_ready, capture addr/data/data_dir; idx = addr / SLAVE_SPAN. idx < NUM_SLAVES -> SETUP; else -> DECERR.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA from captured request. -> ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1, bus signals stable. Only PREADY[idx]/PSLVERR[idx]/PRDATA lane idx are observed.
  - PREADY[idx]=1: resp_err <= PSLVERR[idx], resp_timeout <= 0; read without error: rdata <= lane idx; read with error: rdata <= 0; write: rdata unchanged. -> IDLE, done pulse.
  - PREADY[idx]=0: wait counter increments; when counter reaches TIMEOUT (TIMEOUT>0): abort, resp_err<=1, resp_timeout<=1, rdata<=0 on read. -> IDLE, done pulse.
- DECERR (1 cycle): no PSEL asserted; resp_err<=1, resp_timeout<=0, rdata<=0 on read. -> IDLE, done pulse.
- Wait counter cleared on entry to SETUP; width clog2(TIMEOUT+1).
- PSEL, PENABLE registered outputs; zero in IDLE and DECERR. PADDR/PWRITE/PWDATA hold last captured values outside transfers.

## Timing
- Reset (PRESETn=1 at edge): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, resp_err=0, resp_timeout=0, transaction_done=0; wait counter 0. Reset mid-transfer aborts with no done pulse; next cycle bus idle.
- Accept at edge N (IDLE) -> SETUP cycle N+1 -> ACCESS cycle N+2; with zero wait states transaction_done high in cycle N+3. Each PREADY-low cycle adds one.
- Decode error: accept edge N, DECERR cycle N+1, done cycle N+2.
- Timeout: done exactly TIMEOUT+1 cycles after first ACCESS cycle when PREADY never rises; PREADY rising in the same cycle the counter reaches TIMEOUT counts as success (PREADY wins).
- transaction_done is exactly one cycle; next accept earliest one cycle after done.
- PREADY/PSLVERR of unselected slaves ignored in all states.

## Test plan
- Write 3 to addr 8, slave 0 PREADY tied high -> PSEL=01 one SETUP + one ACCESS cycle, done 3 cycles after accept, resp_err=0; slave memory[8]=3.
- Read addr 1030 (slave 1), slave 1 returns 0x5A after 2 wait states -> PSEL=10, ACCESS lasts 3 cycles, rdata=0x5A, done 5 cycles after accept.
- Read addr 4002 -> no PSEL ever asserted, done 2 cycles after accept, resp_err=1, resp_timeout=0, rdata=0.
- Write to slave 0 with PSLVERR=1 at PREADY -> resp_err=1, rdata unchanged; following read with PSLVERR=0 clears resp_err.
- Slave 1 PREADY stuck low, TIMEOUT=16 -> PSEL/PENABLE drop after 17 ACCESS cycles, resp_err=1, resp_timeout=1; next request completes normally.
- Hold data_valid high across done -> no re-accept in done cycle; PRESETn=1 during ACCESS -> PSEL=0 next cycle, no done pulse.
